// File: rtl/act_sched.sv
// act_sched: streams a run of beats from a source buffer through an external
// activation array into a 2-entry ready/valid output FIFO.
module act_sched #(
  parameter int DEP   = 8,
  parameter int WIDTH = 2,
  parameter int AW    = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_i,
  input  logic [AW-1:0]          base_addr_i,
  input  logic [AW:0]            num_beats_i,
  output logic                   rd_en_o,
  output logic [AW-1:0]          rd_addr_o,
  input  logic [WIDTH*DEP-1:0]   rd_data_i,
  output logic [WIDTH*DEP-1:0]   act_in_o,
  input  logic [WIDTH*DEP-1:0]   act_out_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [WIDTH*DEP-1:0]   out_data_o,
  output logic                   out_last_o,
  output logic                   busy_o,
  output logic                   done_o
);
  localparam int DW = WIDTH * DEP;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;
  localparam logic [AW:0] ONE = 1;

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] base_q;
  logic [AW:0]   num_q, issued_q, popped_q;
  logic          inflight_q;
  logic [DW-1:0] mem_q [2];
  logic          wptr_q, rptr_q;
  logic [1:0]    cnt_q;
  logic          pop, push, accept;
  logic [2:0]    occ;

  // Occupancy counts reads still in flight so the FIFO can never overflow.
  assign pop         = out_valid_o && out_ready_i;
  assign push        = inflight_q;
  assign accept      = state_q == S_IDLE && start_i;
  assign occ         = {1'b0, cnt_q} + {2'b0, inflight_q} - {2'b0, pop};
  assign rd_en_o     = state_q == S_RUN && issued_q < num_q && occ < 3'd2;
  assign rd_addr_o   = base_q + issued_q[AW-1:0];
  assign act_in_o    = rd_data_i;
  assign out_valid_o = cnt_q != 2'd0;
  assign out_data_o  = mem_q[rptr_q];
  assign out_last_o  = out_valid_o && popped_q == num_q - ONE;
  assign busy_o      = state_q != S_IDLE;
  assign done_o      = state_q == S_FIN;

  always_comb begin
    state_d = state_q == S_IDLE ? (start_i ? (num_beats_i == '0 ? S_FIN : S_RUN) : S_IDLE) :
              state_q == S_RUN  ? (pop && out_last_o ? S_FIN : S_RUN) : S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      num_q      <= '0;
      issued_q   <= '0;
      popped_q   <= '0;
      inflight_q <= 1'b0;
      mem_q[0]   <= '0;
      mem_q[1]   <= '0;
      wptr_q     <= 1'b0;
      rptr_q     <= 1'b0;
      cnt_q      <= 2'd0;
    end else begin
      state_q    <= state_d;
      inflight_q <= rd_en_o;
      if (accept) begin
        base_q   <= base_addr_i;
        num_q    <= num_beats_i;
        issued_q <= '0;
        popped_q <= '0;
      end else begin
        if (rd_en_o) issued_q <= issued_q + ONE;
        if (pop)     popped_q <= popped_q + ONE;
      end
      if (push) begin
        mem_q[wptr_q] <= act_out_i;
        wptr_q        <= ~wptr_q;
      end
      if (pop) rptr_q <= ~rptr_q;
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end
endmodule

// File: tb/tb_act_sched.sv
// tb_act_sched: directed checks of act_sched with a ReLU array and a
// registered source-buffer model.
module tb_act_sched;
  localparam int AW = 8;
  localparam int DW = 16;

  logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, out_ready = 1'b1;
  logic [AW-1:0] base = '0, rd_addr;
  logic [AW:0]   num = '0;
  logic [DW-1:0] rd_data = '0, act_in, act_out, out_data;
  logic          rd_en, out_valid, out_last, busy, done;
  logic [DW-1:0] src [256];
  logic [DW-1:0] exp1 [4];
  logic [DW-1:0] obs_q [$];
  logic [AW-1:0] addr_q [$];
  int n_chk = 0, n_fail = 0, n_last = 0, n_done = 0;

  always #5 clk = ~clk;

  act_sched dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .base_addr_i(base), .num_beats_i(num),
    .rd_en_o(rd_en), .rd_addr_o(rd_addr), .rd_data_i(rd_data), .act_in_o(act_in),
    .act_out_i(act_out), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_data_o(out_data), .out_last_o(out_last), .busy_o(busy), .done_o(done)
  );

  function automatic logic [DW-1:0] relu(input logic [DW-1:0] w);
    logic [DW-1:0] r;
    r = w;
    if (w[15]) r[15:8] = 8'h00;
    if (w[7])  r[7:0]  = 8'h00;
    return r;
  endfunction

  assign act_out = relu(act_in);

  always @(posedge clk) if (rd_en) rd_data <= src[rd_addr];

  always @(negedge clk) begin
    if (out_valid && out_ready) obs_q.push_back(out_data);
    if (rd_en) addr_q.push_back(rd_addr);
    if (out_last && out_ready) n_last++;
    if (done) n_done++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clr;
    obs_q.delete();
    addr_q.delete();
    n_last = 0;
    n_done = 0;
  endtask

  task automatic go(input logic [AW-1:0] b, input logic [AW:0] n);
    base  = b;
    num   = n;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  task automatic wait_done;
    for (int i = 0; i < 3000 && n_done == 0; i++) tick;
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_rd_en"}, rd_en, 0);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_last"}, out_last, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_data"}, out_data, 0);
    check({tag, "_addr"}, rd_addr, 0);
  endtask

  task automatic check_run1(input string tag);
    check({tag, "_nobs"}, obs_q.size(), 4);
    check({tag, "_naddr"}, addr_q.size(), 4);
    for (int i = 0; i < obs_q.size() && i < 4; i++) check({tag, "_obs"}, obs_q[i], exp1[i]);
    for (int i = 0; i < addr_q.size() && i < 4; i++) check({tag, "_addr"}, addr_q[i], 32'h10 + i);
    check({tag, "_nlast"}, n_last, 1);
    check({tag, "_ndone"}, n_done, 1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) src[i] = DW'($urandom);
    src[8'h10] = {8'hFD, 8'h05};
    src[8'h11] = {8'h07, 8'hFF};
    src[8'h12] = {8'h00, 8'h80};
    src[8'h13] = {8'h7F, 8'h02};
    exp1[0] = 16'h0005;
    exp1[1] = 16'h0700;
    exp1[2] = 16'h0000;
    exp1[3] = 16'h7F02;

    repeat (2) tick;
    check_reset_outs("rst");
    rst_n = 1'b1;
    tick;

    // Nominal run, ready held high: cycle-exact latency.
    clr;
    go(8'h10, 9'd4);
    for (int c = 1; c <= 8; c++) begin
      check("t1_rd_en", rd_en, (c >= 1 && c <= 4));
      if (c >= 1 && c <= 4) check("t1_rd_addr", rd_addr, 32'h10 + c - 1);
      check("t1_valid", out_valid, (c >= 3 && c <= 6));
      if (c >= 3 && c <= 6) check("t1_data", out_data, exp1[c-3]);
      check("t1_last", out_last, c == 6);
      check("t1_done", done, c == 7);
      check("t1_busy", busy, c <= 7);
      tick;
    end
    check_run1("t1");

    // Back-pressure: ready low through cycle 8.
    clr;
    out_ready = 1'b0;
    go(8'h10, 9'd4);
    repeat (8) tick;
    check("t2_stall_reads", addr_q.size(), 2);
    check("t2_stall_valid", out_valid, 1);
    check("t2_stall_data", out_data, exp1[0]);
    check("t2_stall_rd_en", rd_en, 0);
    out_ready = 1'b1;
    wait_done;
    check("t2_idle", busy, 0);
    check_run1("t2");

    // Empty run.
    clr;
    go(8'h20, 9'd0);
    check("t3_done1", done, 1);
    check("t3_busy1", busy, 1);
    check("t3_rd_en1", rd_en, 0);
    tick;
    check("t3_busy2", busy, 0);
    check("t3_done2", done, 0);
    repeat (3) tick;
    check("t3_ndone", n_done, 1);
    check("t3_nobs", obs_q.size(), 0);
    check("t3_naddr", addr_q.size(), 0);

    // Start pulsed mid-run must be ignored.
    clr;
    go(8'h10, 9'd4);
    tick;
    go(8'h40, 9'd2);
    wait_done;
    check_run1("t4");
    tick;

    // Asynchronous reset mid-run, then a wrapping run.
    clr;
    go(8'h10, 9'd4);
    repeat (3) tick;
    rst_n = 1'b0;
    #1;
    check_reset_outs("t5_rst");
    tick;
    rst_n = 1'b1;
    tick;
    clr;
    go(8'hFE, 9'd3);
    wait_done;
    check("t5_naddr", addr_q.size(), 3);
    for (int i = 0; i < addr_q.size() && i < 3; i++) check("t5_addr", addr_q[i], (32'hFE + i) & 32'hFF);
    check("t5_nobs", obs_q.size(), 3);
    for (int i = 0; i < obs_q.size() && i < 3; i++) check("t5_obs", obs_q[i], relu(src[8'(8'hFE + i)]));
    check("t5_ndone", n_done, 1);
    tick;

    // Full-range run with random back-pressure.
    clr;
    go(8'h00, 9'd256);
    for (int i = 0; i < 3000 && n_done == 0; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      tick;
    end
    out_ready = 1'b1;
    check("t6_nobs", obs_q.size(), 256);
    for (int i = 0; i < obs_q.size() && i < 256; i++) check("t6_obs", obs_q[i], relu(src[i]));
    check("t6_nlast", n_last, 1);
    check("t6_ndone", n_done, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
